// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - shared stepper types and default widths
package stepper_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int PER_W_DEF = 20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEL,
        ST_CRUISE,
        ST_DECEL,
        ST_DONE
    } state_t;

endpackage

// File: rtl/step_profile_gen_if.sv
// rtl/step_profile_gen_if.sv - move request and status bundle for step_profile_gen
interface step_profile_gen_if
    import stepper_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             start;
    logic             abort;
    logic             dir_i;
    logic [CNT_W-1:0] steps_i;
    logic             enable_o;
    logic             dir_o;
    logic             step_o;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] steps_done_o;

    modport master (
        output start, abort, dir_i, steps_i,
        input  enable_o, dir_o, step_o, busy_o, done_o, steps_done_o
    );

    modport slave (
        input  start, abort, dir_i, steps_i,
        output enable_o, dir_o, step_o, busy_o, done_o, steps_done_o
    );

endinterface

// File: rtl/step_timer.sv
// rtl/step_timer.sv - loadable step-period down-counter with zero flag
module step_timer
    import stepper_pkg::*;
#(
    parameter int PER_W = PER_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PER_W-1:0] load_val,
    input  logic             run,
    output logic             zero
);

    logic [PER_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - PER_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/step_profile_gen.sv
// rtl/step_profile_gen.sv - trapezoidal step-train generator (accel, cruise, decel)
module step_profile_gen
    import stepper_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int PER_W        = PER_W_DEF,
    parameter int START_PERIOD = 50000,
    parameter int MIN_PERIOD   = 5000,
    parameter int ACCEL_DELTA  = 500
) (
    input  logic              clk,
    input  logic              rst,
    step_profile_gen_if.slave bus
);

    localparam logic [PER_W-1:0] START_P = PER_W'(START_PERIOD);
    localparam logic [PER_W-1:0] MIN_P   = PER_W'(MIN_PERIOD);
    localparam logic [PER_W-1:0] DELTA_P = PER_W'(ACCEL_DELTA);
    localparam logic [PER_W:0]   START_X = (PER_W+1)'(START_PERIOD);
    localparam logic [PER_W:0]   MIN_X   = (PER_W+1)'(MIN_PERIOD);
    localparam logic [PER_W:0]   DELTA_X = (PER_W+1)'(ACCEL_DELTA);

    // One extra bit keeps the saturation compares from wrapping.
    function automatic logic [PER_W-1:0] slow_down(input logic [PER_W-1:0] p);
        logic [PER_W:0] s;
        s = {1'b0, p} + DELTA_X;
        return (s > START_X) ? START_P : s[PER_W-1:0];
    endfunction

    function automatic logic [PER_W-1:0] speed_up(input logic [PER_W-1:0] p);
        return ({1'b0, p} < (MIN_X + DELTA_X)) ? MIN_P : (p - DELTA_P);
    endfunction

    state_t           state, state_n;
    logic [PER_W-1:0] period, period_n;
    logic [CNT_W-1:0] ramp, ramp_n;
    logic [CNT_W-1:0] steps_lat, steps_lat_n;
    logic [CNT_W-1:0] steps_done, steps_done_n;
    logic [CNT_W-1:0] rem;
    logic             dir, dir_n;
    logic             enable, enable_n;
    logic             step, step_n;
    logic             busy, busy_n;
    logic             done, done_n;
    logic             tmr_load, tmr_run, tmr_zero;
    logic [PER_W-1:0] tmr_val;

    step_timer #(.PER_W(PER_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .run      (tmr_run),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            period     <= START_P;
            ramp       <= '0;
            steps_lat  <= '0;
            steps_done <= '0;
            dir        <= 1'b0;
            enable     <= 1'b0;
            step       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            period     <= period_n;
            ramp       <= ramp_n;
            steps_lat  <= steps_lat_n;
            steps_done <= steps_done_n;
            dir        <= dir_n;
            enable     <= enable_n;
            step       <= step_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    // Steps still owed after the one being strobed now.
    assign rem = steps_lat - steps_done - CNT_W'(1);

    always_comb begin
        state_n      = state;
        period_n     = period;
        ramp_n       = ramp;
        steps_lat_n  = steps_lat;
        steps_done_n = steps_done;
        dir_n        = dir;
        enable_n     = enable;
        busy_n       = busy;
        step_n       = 1'b0;
        done_n       = 1'b0;
        tmr_load     = 1'b0;
        tmr_run      = 1'b0;
        tmr_val      = START_P - PER_W'(1);
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    steps_done_n = '0;
                    if (bus.steps_i != '0) begin
                        steps_lat_n = bus.steps_i;
                        dir_n       = bus.dir_i;
                        enable_n    = 1'b1;
                        busy_n      = 1'b1;
                        tmr_load    = 1'b1;
                        state_n     = ST_ACCEL;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_ACCEL, ST_CRUISE, ST_DECEL: begin
                tmr_run = 1'b1;
                if (tmr_zero) begin
                    step_n       = 1'b1;
                    steps_done_n = steps_done + CNT_W'(1);
                    if (rem == '0) begin
                        state_n = ST_DONE;
                    end else if (rem <= ramp) begin
                        state_n  = ST_DECEL;
                        period_n = slow_down(period);
                    end else if (state == ST_ACCEL) begin
                        period_n = speed_up(period);
                        ramp_n   = ramp + CNT_W'(1);
                        if (period_n == MIN_P) state_n = ST_CRUISE;
                    end
                    tmr_load = 1'b1;
                    tmr_val  = period_n - PER_W'(1);
                end
                if (bus.abort) state_n = ST_DONE;
            end
            ST_DONE: begin
                done_n   = 1'b1;
                enable_n = 1'b0;
                busy_n   = 1'b0;
                period_n = START_P;
                ramp_n   = '0;
                state_n  = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.enable_o     = enable;
    assign bus.dir_o        = dir;
    assign bus.step_o       = step;
    assign bus.busy_o       = busy;
    assign bus.done_o       = done;
    assign bus.steps_done_o = steps_done;

endmodule

// File: tb/tb_step_profile_gen.sv
// tb/tb_step_profile_gen.sv - self-checking bench for step_profile_gen
module tb_step_profile_gen;

    localparam int SP = 20;
    localparam int MP = 8;
    localparam int AD = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    step_profile_gen_if #(.CNT_W(CW)) bus ();

    step_profile_gen #(
        .CNT_W        (CW),
        .PER_W        (20),
        .START_PERIOD (SP),
        .MIN_PERIOD   (MP),
        .ACCEL_DELTA  (AD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit model_on = 1'b0;
    int exp_times[$];
    int exp_done_t = 0;
    bit exp_moving = 1'b0;
    bit exp_dir = 1'b0;
    int act_times[$];
    int act_done_t = -1;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // Step times (edges after the accept edge) from the per-step ramp rules.
    task automatic model_move(input int n, input int abort_at);
        int period, ramp, ph, t, rem;
        exp_times.delete();
        period = SP; ramp = 0; ph = 0; t = 0;
        exp_moving = (n > 0);
        for (int k = 1; k <= n; k++) begin
            t += period;
            exp_times.push_back(t);
            rem = n - k;
            if (rem == 0) break;
            if (rem <= ramp) begin
                ph = 2;
                period = (period + AD > SP) ? SP : period + AD;
            end else if (ph == 0) begin
                period = (period - AD < MP) ? MP : period - AD;
                ramp++;
                if (period == MP) ph = 1;
            end
        end
        exp_done_t = (n == 0) ? 1 : t + 1;
        if (abort_at > 0 && n > 0 && abort_at < t) begin
            while (exp_times.size() > 0 && exp_times[$] > abort_at) void'(exp_times.pop_back());
            exp_done_t = abort_at + 1;
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            int t, ecnt;
            bit estep, ebusy;
            t = cyc - acc_cyc;
            estep = 1'b0;
            ecnt = 0;
            foreach (exp_times[i]) begin
                if (exp_times[i] == t) estep = 1'b1;
                if (exp_times[i] <= t) ecnt++;
            end
            ebusy = exp_moving && (t < exp_done_t);
            if (bus.step_o) act_times.push_back(t);
            if (bus.done_o && act_done_t < 0) act_done_t = t;
            chk("step_o", bus.step_o, estep);
            chk("done_o", bus.done_o, (t == exp_done_t));
            chk("busy_o", bus.busy_o, ebusy);
            chk("enable_o", bus.enable_o, ebusy);
            chk("steps_done_o", bus.steps_done_o, ecnt);
            chk("dir_o", bus.dir_o, exp_dir);
        end
    end

    task automatic run_move(input int n, input bit d, input int abort_at,
                            input int spur_at, input int stop_at);
        int t;
        tick();
        model_move(n, abort_at);
        if (n > 0) exp_dir = d;
        act_times.delete();
        act_done_t = -1;
        acc_cyc = cyc + 1;
        bus.start = 1'b1;
        bus.dir_i = d;
        bus.steps_i = CW'(n);
        model_on = 1'b1;
        for (int i = 0; i <= exp_done_t + 3; i++) begin
            tick();
            t = cyc - acc_cyc;
            bus.start = 1'b0;
            bus.abort = 1'b0;
            if (stop_at > 0 && t == stop_at) begin
                model_on = 1'b0;
                return;
            end
            if (t == abort_at - 1) bus.abort = 1'b1;
            if (t == spur_at) begin
                bus.start = 1'b1;
                bus.steps_i = CW'(2);
                bus.dir_i = ~d;
            end
        end
        model_on = 1'b0;
    endtask

    task automatic check_seq(input string name, input int lit[$]);
        int prev;
        prev = 0;
        chk({name, "_count"}, act_times.size(), lit.size());
        for (int i = 0; i < act_times.size() && i < lit.size(); i++) begin
            chk(name, act_times[i] - prev, lit[i]);
            prev = act_times[i];
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_enable"}, bus.enable_o, 0);
        chk({name, "_dir"}, bus.dir_o, 0);
        chk({name, "_step"}, bus.step_o, 0);
        chk({name, "_busy"}, bus.busy_o, 0);
        chk({name, "_done"}, bus.done_o, 0);
        chk({name, "_steps_done"}, bus.steps_done_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int q[$];
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.dir_i = 1'b0;
        bus.steps_i = '0;
        #2 rst = 1'b0;
        #1 chk_all_zero("reset");
        repeat (3) tick();
        rst = 1'b1;
        tick();

        run_move(10, 1'b1, -1, -1, -1);
        q = '{20, 16, 12, 8, 8, 8, 8, 12, 16, 20};
        check_seq("ivl_10", q);
        chk("done_t_10", act_done_t, 129);
        chk("steps_done_10", bus.steps_done_o, 10);
        chk("dir_10", bus.dir_o, 1);

        run_move(3, 1'b0, -1, -1, -1);
        q = '{20, 16, 20};
        check_seq("ivl_3", q);
        chk("done_t_3", act_done_t, 57);
        chk("dir_3", bus.dir_o, 0);

        run_move(0, 1'b1, -1, -1, -1);
        chk("done_t_0", act_done_t, 1);
        chk("steps_0", act_times.size(), 0);
        chk("dir_0", bus.dir_o, 0);

        run_move(10, 1'b1, 50, -1, -1);
        q = '{20, 16, 12};
        check_seq("ivl_abort", q);
        chk("done_t_abort", act_done_t, 51);
        chk("steps_done_abort", bus.steps_done_o, 3);
        chk("enable_abort", bus.enable_o, 0);

        run_move(10, 1'b1, -1, 30, -1);
        q = '{20, 16, 12, 8, 8, 8, 8, 12, 16, 20};
        check_seq("ivl_spur", q);
        chk("done_t_spur", act_done_t, 129);
        chk("steps_done_spur", bus.steps_done_o, 10);

        run_move(10, 1'b1, -1, -1, 60);
        rst = 1'b0;
        #1 chk_all_zero("mid_reset");
        exp_dir = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("post_reset_busy", bus.busy_o, 0);

        run_move(3, 1'b1, -1, -1, -1);
        q = '{20, 16, 20};
        check_seq("ivl_after_reset", q);
        chk("done_t_after_reset", act_done_t, 57);

        run_move(1, 1'b0, -1, -1, -1);
        q = '{20};
        check_seq("ivl_1", q);
        chk("done_t_1", act_done_t, 21);
        chk("steps_done_1", bus.steps_done_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
